button_conditioner: RTL and testbench

Input conditioning stage that turns a raw, bouncing, asynchronous push-button into clean single-cycle pulses and a stable level for the toggle/data flip-flop stages downstream. It synchronises the raw input, debounces it with a consecutive-sample counter, and runs a small state machine that emits press, release and optional auto-repeat pulses. Its `toggle_out` connects directly to a T flip-flop's toggle input, and `level_out` to a D flip-flop's data input.

---
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, consecutive-sample debouncer and a
// small auto-repeat state machine producing registered press/release/repeat pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_in,
    output logic       level_out,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       toggle_out,
    output logic [1:0] fsm_state
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_V    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RP_V    = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEATING  = 2'd2
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;

    logic mismatch;
    logic flip;
    logic press_edge;
    logic release_edge;
    logic repeat_due;

    // Everything below is decoded from registers only, so toggle_out has no path from button_in.
    assign mismatch     = sync2 ^ level_out;
    assign flip         = mismatch && (db_cnt == DB_LAST);
    assign press_edge   = flip && !level_out;
    assign release_edge = flip && level_out;

    // A release on the same edge as a scheduled repeat wins and swallows the repeat.
    assign repeat_due = !release_edge &&
                        (((state == WAIT_DELAY) && (rep_cnt == RD_V)) ||
                         ((state == REPEATING)  && (rep_cnt == RP_V)));

    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            db_cnt        <= '0;
            level_out     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            toggle_out    <= 1'b0;
            rep_cnt       <= '0;
            state         <= IDLE;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;

            if (!mismatch || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            if (flip) begin
                level_out <= ~level_out;
            end

            press_pulse   <= press_edge;
            release_pulse <= release_edge;
            repeat_pulse  <= repeat_due;
            toggle_out    <= press_edge | repeat_due;

            if (release_edge) begin
                state   <= IDLE;
                rep_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press_edge && (REPEAT_DELAY > 0)) begin
                            state   <= WAIT_DELAY;
                            rep_cnt <= R_ONE;
                        end
                    end
                    WAIT_DELAY: begin
                        if (rep_cnt == RD_V) begin
                            state   <= REPEATING;
                            rep_cnt <= R_ONE;
                        end else begin
                            rep_cnt <= rep_cnt + R_ONE;
                        end
                    end
                    REPEATING: begin
                        if (rep_cnt == RP_V) begin
                            rep_cnt <= R_ONE;
                        end else begin
                            rep_cnt <= rep_cnt + R_ONE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: instance a (debounce 4, no repeat) and instance b (debounce 2,
// repeat delay 6, period 3) share one clock; each task checks its own scenario.
module tb_button_conditioner;

    logic       clock;
    logic       reset_a, button_a;
    logic       level_a, press_a, release_a, repeat_a, toggle_a;
    logic [1:0] state_a;
    logic       reset_b, button_b;
    logic       level_b, press_b, release_b, repeat_b, toggle_b;
    logic [1:0] state_b;

    int tests_run    = 0;
    int tests_failed = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (0),
        .REPEAT_PERIOD  (8)
    ) dut_a (
        .clock        (clock),
        .reset        (reset_a),
        .button_in    (button_a),
        .level_out    (level_a),
        .press_pulse  (press_a),
        .release_pulse(release_a),
        .repeat_pulse (repeat_a),
        .toggle_out   (toggle_a),
        .fsm_state    (state_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(2),
        .REPEAT_DELAY   (6),
        .REPEAT_PERIOD  (3)
    ) dut_b (
        .clock        (clock),
        .reset        (reset_b),
        .button_in    (button_b),
        .level_out    (level_b),
        .press_pulse  (press_b),
        .release_pulse(release_b),
        .repeat_pulse (repeat_b),
        .toggle_out   (toggle_b),
        .fsm_state    (state_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        logic [4:0] outs;
        reset_a  = 1'b1;
        button_a = 1'b0;
        tick;
        tick;
        outs = {level_a, press_a, release_a, repeat_a, toggle_a};
        tests_run++;
        if (outs !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 00000", outs);
        end
        tests_run++;
        if (state_a !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want 0", state_a);
        end
        // Button already high when reset lifts: first edge afterwards is edge N, press at N+5.
        button_a = 1'b1;
        reset_a  = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick;
            tests_run++;
            if (press_a !== (t == 6)) begin
                tests_failed++;
                $display("FAIL reset_release_press t=%0d: got %b want %b", t, press_a, (t == 6));
            end
        end
        tests_run++;
        if ({level_a, toggle_a} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_release_level: got %b want 11", {level_a, toggle_a});
        end
        tick;
        tick;
        // Asynchronous reset mid-cycle while the button is held.
        #2;
        reset_a = 1'b1;
        #1;
        outs = {level_a, press_a, release_a, repeat_a, toggle_a};
        tests_run++;
        if (outs !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: got %b want 00000", outs);
        end
        tick;
        tick;
        tests_run++;
        if (level_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held_level: got %b want 0", level_a);
        end
        reset_a = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick;
            tests_run++;
            if (press_a !== (t == 6)) begin
                tests_failed++;
                $display("FAIL reset_new_press t=%0d: got %b want %b", t, press_a, (t == 6));
            end
        end
    endtask

    task automatic test_release;
        button_a = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick;
            tests_run++;
            if (release_a !== (t == 6)) begin
                tests_failed++;
                $display("FAIL release_pulse t=%0d: got %b want %b", t, release_a, (t == 6));
            end
            tests_run++;
            if (level_a !== (t < 6)) begin
                tests_failed++;
                $display("FAIL release_level t=%0d: got %b want %b", t, level_a, (t < 6));
            end
            tests_run++;
            if (toggle_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL release_toggle t=%0d: got %b want 0", t, toggle_a);
            end
        end
    endtask

    task automatic test_clean_press;
        int reps;
        button_a = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick;
            tests_run++;
            if (press_a !== (t == 6)) begin
                tests_failed++;
                $display("FAIL clean_press t=%0d: got %b want %b", t, press_a, (t == 6));
            end
            tests_run++;
            if (toggle_a !== (t == 6)) begin
                tests_failed++;
                $display("FAIL clean_toggle t=%0d: got %b want %b", t, toggle_a, (t == 6));
            end
        end
        tests_run++;
        if (level_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_level: got %b want 1", level_a);
        end
        reps = 0;
        for (int t = 0; t < 20; t++) begin
            tick;
            if (repeat_a === 1'b1 || state_a !== 2'd0) reps++;
        end
        tests_run++;
        if (reps !== 0) begin
            tests_failed++;
            $display("FAIL clean_no_repeat: got %0d repeat cycles want 0", reps);
        end
        test_release;
    endtask

    task automatic test_bounce;
        logic [7:0] pat;
        int         presses;
        int         press_t;
        pat     = 8'b1111_0111;
        presses = 0;
        press_t = 0;
        for (int t = 1; t <= 14; t++) begin
            button_a = (t <= 8) ? pat[t-1] : 1'b1;
            tick;
            if (press_a === 1'b1) begin
                presses++;
                press_t = t;
            end
            if (t < 10) begin
                tests_run++;
                if (level_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bounce_early_level t=%0d: got %b want 0", t, level_a);
                end
            end
        end
        tests_run++;
        if (presses !== 1) begin
            tests_failed++;
            $display("FAIL bounce_press_count: got %0d want 1", presses);
        end
        tests_run++;
        if (press_t !== 10) begin
            tests_failed++;
            $display("FAIL bounce_press_edge: got tick %0d want 10", press_t);
        end
    endtask

    // Resets instance b, presses its button and checks the press lands 3 edges later.
    task automatic press_b_fresh;
        reset_b  = 1'b1;
        button_b = 1'b0;
        tick;
        tick;
        reset_b = 1'b0;
        tick;
        button_b = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick;
            tests_run++;
            if (press_b !== (t == 4)) begin
                tests_failed++;
                $display("FAIL b_press t=%0d: got %b want %b", t, press_b, (t == 4));
            end
        end
        tests_run++;
        if (toggle_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL b_press_toggle: got %b want 1", toggle_b);
        end
    endtask

    task automatic test_auto_repeat;
        logic exp_rep;
        press_b_fresh;
        for (int k = 1; k <= 14; k++) begin
            tick;
            exp_rep = (k == 6) || (k == 9) || (k == 12);
            tests_run++;
            if (repeat_b !== exp_rep) begin
                tests_failed++;
                $display("FAIL repeat_pulse P+%0d: got %b want %b", k, repeat_b, exp_rep);
            end
            tests_run++;
            if (toggle_b !== exp_rep) begin
                tests_failed++;
                $display("FAIL repeat_toggle P+%0d: got %b want %b", k, toggle_b, exp_rep);
            end
            tests_run++;
            if (press_b !== 1'b0) begin
                tests_failed++;
                $display("FAIL repeat_no_press P+%0d: got %b want 0", k, press_b);
            end
            if (k == 1) begin
                tests_run++;
                if (state_b !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL repeat_state_wait: got %0d want 1", state_b);
                end
            end
            if (k == 6) begin
                tests_run++;
                if (state_b !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL repeat_state_rep: got %0d want 2", state_b);
                end
            end
        end
    endtask

    task automatic test_release_collision;
        logic exp_rep;
        logic exp_rel;
        press_b_fresh;
        for (int k = 1; k <= 14; k++) begin
            if (k == 6) button_b = 1'b0;
            tick;
            exp_rep = (k == 6);
            exp_rel = (k == 9);
            tests_run++;
            if (repeat_b !== exp_rep) begin
                tests_failed++;
                $display("FAIL collide_repeat P+%0d: got %b want %b", k, repeat_b, exp_rep);
            end
            tests_run++;
            if (release_b !== exp_rel) begin
                tests_failed++;
                $display("FAIL collide_release P+%0d: got %b want %b", k, release_b, exp_rel);
            end
            tests_run++;
            if (toggle_b !== exp_rep) begin
                tests_failed++;
                $display("FAIL collide_toggle P+%0d: got %b want %b", k, toggle_b, exp_rep);
            end
            if (k == 9) begin
                tests_run++;
                if (state_b !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL collide_state: got %0d want 0", state_b);
                end
            end
        end
        tests_run++;
        if (level_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide_level: got %b want 0", level_b);
        end
    endtask

    task automatic test_glitch_held;
        logic exp_rep;
        press_b_fresh;
        for (int k = 1; k <= 13; k++) begin
            button_b = (k == 2) ? 1'b0 : 1'b1;
            tick;
            exp_rep = (k == 6) || (k == 9) || (k == 12);
            tests_run++;
            if (repeat_b !== exp_rep) begin
                tests_failed++;
                $display("FAIL glitch_repeat P+%0d: got %b want %b", k, repeat_b, exp_rep);
            end
            tests_run++;
            if ({level_b, release_b, press_b} !== 3'b100) begin
                tests_failed++;
                $display("FAIL glitch_level P+%0d: got %b want 100", k, {level_b, release_b, press_b});
            end
        end
    endtask

    initial begin
        reset_a  = 1'b1;
        reset_b  = 1'b1;
        button_a = 1'b0;
        button_b = 1'b0;
        test_reset;
        test_release;
        test_clean_press;
        test_bounce;
        test_auto_repeat;
        test_release_collision;
        test_glitch_held;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
